level_timer: RTL and testbench
==============================

LEVEL_TIMER -- requirements
Module: level_timer

Interface
- REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per countdown second.
- REQ-002 SHALL have parameter START_SEC, default 60: base load value in seconds at level 0.
- REQ-003 SHALL have parameter SEC_W, default 6: width of the seconds count; START_SEC < 2^SEC_W.
- REQ-004 SHALL have parameter LEVEL_W, default 4: width of level input.
- REQ-005 SHALL have parameter DEC_PER_LEVEL, default 5: seconds removed from load value per level.
- REQ-006 SHALL have parameter MIN_SEC, default 10: load-value floor, 1 <= MIN_SEC <= START_SEC.
- REQ-007 SHALL have parameter WARN_SEC, default 10: low-time warning threshold.
- REQ-008 SHALL have parameter BONUS_SEC, default 5: seconds added per bonus pulse.
- REQ-009 SHALL have port clk, input, 1: single system clock.
- REQ-010 SHALL have port Reset, input, 1: asynchronous active-high reset.
- REQ-011 SHALL have port gameStart, input, 1: high while a game is in progress.
- REQ-012 SHALL have port gameEnd, input, 1: high when the game is over.
- REQ-013 SHALL have port pause, input, 1: level-sensitive freeze request.
- REQ-014 SHALL have port level, input, LEVEL_W: current level number.
- REQ-015 SHALL have port bonus, input, 1: one-cycle bonus-time pulse (LEVEL_TIMER_BONUS_EN only).
- REQ-016 SHALL have port tim, output, SEC_W: remaining whole seconds.
- REQ-017 SHALL have port warn, output, 1: high when RUN or PAUSE and 0 < tim <= WARN_SEC.
- REQ-018 SHALL have port expired, output, 1: one-cycle pulse when tim reaches 0.
- REQ-019 SHALL have port running, output, 1: high in RUN state only.

Function
- REQ-020 SHALL compute load = max(START_SEC - level*DEC_PER_LEVEL, MIN_SEC), using signed or widened arithmetic so that no underflow wraps.
- REQ-021 SHALL implement states IDLE, RUN, PAUSE, DONE, with all registers clocked on posedge clk.
- REQ-022 SHALL hold a prescaler counting CLK_HZ-1 down to 0; a tick is the cycle in which the prescaler is at 0 in RUN, and the prescaler then reloads CLK_HZ-1.
- REQ-023 SHALL apply per-cycle priority: level > prevLevel, then (!gameStart | gameEnd), then pause, then tick.
- REQ-024 SHALL, on level > prevLevel in any state: update prevLevel, set tim = load, reload the prescaler, and go to RUN if gameStart & !gameEnd, else IDLE.
- REQ-025 SHALL, on !gameStart | gameEnd: go to IDLE, set tim = load, and reload the prescaler.
- REQ-026 SHALL go from IDLE to RUN when gameStart & !gameEnd & !pause.
- REQ-027 SHALL go from RUN to PAUSE when pause is high; in PAUSE the prescaler and tim hold.
- REQ-028 SHALL go from PAUSE to RUN when pause is low, resuming the prescaler value that was held.
- REQ-029 SHALL, on a RUN tick with tim > 1, set tim = tim-1.
- REQ-030 SHALL, on a RUN tick with tim == 1, set tim = 0, go to DONE, and assert expired for exactly that next cycle.
- REQ-031 SHALL hold tim at 0 in DONE with no further expired pulses; DONE exits only via REQ-024 or REQ-025.
- REQ-032 SHALL not decrement on a level decrease; prevLevel updates only on an increase.

Reset
- REQ-033 SHALL, while Reset is high (asynchronous): state = IDLE, tim = START_SEC, prescaler = CLK_HZ-1, prevLevel = 0, expired = 0, warn = 0, running = 0.
- REQ-034 SHALL leave IDLE on Reset release only through REQ-026 or REQ-024; Reset mid-count discards remaining time.

Configuration
- REQ-035 SHALL define the bonus feature with macro LEVEL_TIMER_BONUS_EN.
- REQ-036 SHALL, with the macro defined: on bonus in RUN or PAUSE, set tim = min(tim+BONUS_SEC, 2^SEC_W-1) in the same edge; a bonus coinciding with a tick applies both, as tim-1+BONUS_SEC saturated; bonus is ignored in IDLE and DONE.
- REQ-037 SHALL, without the macro: omit the bonus port and all bonus logic; behaviour is otherwise identical.

Verification (CLK_HZ=4, START_SEC=8, DEC_PER_LEVEL=3, MIN_SEC=2, WARN_SEC=3, BONUS_SEC=5, SEC_W=4)
- REQ-038 SHALL cover: Reset, then gameStart=1 -> tim 8,7,...,1,0 each 4 cycles apart; expired high 1 cycle; DONE; tim stays 0.
- REQ-039 SHALL cover: level 0->1 mid-count -> tim=5 at the next edge, prescaler restarted; level 1->3 -> tim=2 (floor); level 3->2 -> no change.
- REQ-040 SHALL cover: pause for 10 cycles at tim=6 -> tim holds 6, running=0; after release the next decrement comes after the remaining prescaler cycles.
- REQ-041 SHALL cover: gameEnd=1 at tim=4 -> IDLE, tim=load, warn=0; gameEnd=0 -> restart from load.
- REQ-042 SHALL cover: with the macro, bonus at tim=12 -> tim=15 (saturate); bonus on tick cycle at tim=3 -> tim=7; warn drops when tim > 3.
- REQ-043 SHALL cover: Reset asserted mid-RUN between clock edges -> outputs reach reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/level_timer.sv
// Level-scaled countdown timer: loads max(START_SEC - level*DEC_PER_LEVEL, MIN_SEC) seconds and counts down in RUN.
// Defining LEVEL_TIMER_BONUS_EN adds the bonus input, which adds BONUS_SEC (saturating) in RUN or PAUSE.
module level_timer #(
    parameter int CLK_HZ        = 50000000,
    parameter int START_SEC     = 60,
    parameter int SEC_W         = 6,
    parameter int LEVEL_W       = 4,
    parameter int DEC_PER_LEVEL = 5,
    parameter int MIN_SEC       = 10,
    parameter int WARN_SEC      = 10,
    parameter int BONUS_SEC     = 5
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               gameStart,
    input  logic               gameEnd,
    input  logic               pause,
    input  logic [LEVEL_W-1:0] level,
`ifdef LEVEL_TIMER_BONUS_EN
    input  logic               bonus,
`endif
    output logic [SEC_W-1:0]   tim,
    output logic               warn,
    output logic               expired,
    output logic               running
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(CLK_HZ - 1);
    localparam int TIM_MAX = (1 << SEC_W) - 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t               state, state_n;
    logic [SEC_W-1:0]     tim_n;
    logic [PRESC_W-1:0]   presc, presc_n;
    logic [LEVEL_W-1:0]   prev_level, prev_n;
    logic                 expired_n;
    logic                 tick;
    logic                 bonus_hit;
    logic [SEC_W-1:0]     load_val;
    int                   load_int;
    int                   tim_calc;

    // Signed 32-bit arithmetic so a large level cannot wrap below the floor.
    always_comb begin
        load_int = START_SEC - int'(level) * DEC_PER_LEVEL;
        load_val = (load_int < MIN_SEC) ? SEC_W'(MIN_SEC) : SEC_W'(load_int);
    end

`ifdef LEVEL_TIMER_BONUS_EN
    assign bonus_hit = bonus && (state == RUN || state == PAUSE);
`else
    assign bonus_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            tim        <= SEC_W'(START_SEC);
            presc      <= PRESC_RELOAD;
            prev_level <= '0;
            expired    <= 1'b0;
        end else begin
            state      <= state_n;
            tim        <= tim_n;
            presc      <= presc_n;
            prev_level <= prev_n;
            expired    <= expired_n;
        end
    end

    always_comb begin
        state_n   = state;
        tim_n     = tim;
        presc_n   = presc;
        prev_n    = prev_level;
        expired_n = 1'b0;
        tick      = 1'b0;
        tim_calc  = int'(tim);
        if (level > prev_level) begin
            prev_n  = level;
            tim_n   = load_val;
            presc_n = PRESC_RELOAD;
            state_n = (gameStart && !gameEnd) ? RUN : IDLE;
        end else if (!gameStart || gameEnd) begin
            state_n = IDLE;
            tim_n   = load_val;
            presc_n = PRESC_RELOAD;
        end else begin
            case (state)
                IDLE:    if (!pause) state_n = RUN;
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (presc == '0) begin
                        tick     = 1'b1;
                        presc_n  = PRESC_RELOAD;
                        tim_calc = tim_calc - 1;
                    end else begin
                        presc_n = presc - PRESC_W'(1);
                    end
                end
                PAUSE:   if (!pause) state_n = RUN;
                default: ;
            endcase
            // A bonus on the tick edge is added after the decrement.
            if (bonus_hit)
                tim_calc = (tim_calc + BONUS_SEC > TIM_MAX) ? TIM_MAX : tim_calc + BONUS_SEC;
            if (tick && tim_calc <= 0) begin
                tim_calc  = 0;
                state_n   = DONE;
                expired_n = 1'b1;
            end
            tim_n = SEC_W'(tim_calc);
        end
    end

    assign running = (state == RUN);
    assign warn    = (state == RUN || state == PAUSE) && (tim != '0) && (int'(tim) <= WARN_SEC);

endmodule

// File: tb/tb_level_timer.sv
// Bench for level_timer: directed scenarios then randomized traffic, checked every cycle
// against a seconds/cycles-remaining reference model; bonus scenarios need LEVEL_TIMER_BONUS_EN.
`timescale 1ns/1ps
module tb_level_timer;

    localparam int CLK_HZ    = 4;
    localparam int START_SEC = 8;
    localparam int SEC_W     = 4;
    localparam int LEVEL_W   = 4;
    localparam int DEC       = 3;
    localparam int MIN_SEC   = 2;
    localparam int WARN_SEC  = 3;
    localparam int BONUS_SEC = 5;
    localparam int TIM_MAX   = 15;
`ifdef LEVEL_TIMER_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic               clk = 1'b0;
    logic               Reset;
    logic               gameStart, gameEnd, pause, bonus;
    logic [LEVEL_W-1:0] level;
    logic [SEC_W-1:0]   tim;
    logic               warn, expired, running;

    int  checks = 0;
    int  errors = 0;
    int  exp_seen = 0;
    int  m_mode, m_tim, m_left, m_prev;
    bit  m_exp;

    level_timer #(
        .CLK_HZ(CLK_HZ), .START_SEC(START_SEC), .SEC_W(SEC_W), .LEVEL_W(LEVEL_W),
        .DEC_PER_LEVEL(DEC), .MIN_SEC(MIN_SEC), .WARN_SEC(WARN_SEC), .BONUS_SEC(BONUS_SEC)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .gameStart(gameStart),
        .gameEnd(gameEnd),
        .pause(pause),
        .level(level),
`ifdef LEVEL_TIMER_BONUS_EN
        .bonus(bonus),
`endif
        .tim(tim),
        .warn(warn),
        .expired(expired),
        .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: m_left is RUN cycles still to elapse before the next one-second tick.
    task automatic model_reset();
        m_mode = M_IDLE;
        m_tim  = START_SEC;
        m_left = CLK_HZ;
        m_prev = 0;
        m_exp  = 1'b0;
    endtask

    function automatic int load_of(input int lv);
        int v;
        v = START_SEC - lv * DEC;
        return (v < MIN_SEC) ? MIN_SEC : v;
    endfunction

    task automatic model_edge();
        int  t;
        bit  ticked;
        m_exp = 1'b0;
        if (int'(level) > m_prev) begin
            m_prev = int'(level);
            m_tim  = load_of(int'(level));
            m_left = CLK_HZ;
            m_mode = (gameStart && !gameEnd) ? M_RUN : M_IDLE;
        end else if (!gameStart || gameEnd) begin
            m_mode = M_IDLE;
            m_tim  = load_of(int'(level));
            m_left = CLK_HZ;
        end else begin
            t = m_tim;
            ticked = 1'b0;
            if (m_mode == M_RUN && !pause) begin
                m_left--;
                if (m_left == 0) begin
                    ticked = 1'b1;
                    m_left = CLK_HZ;
                    t--;
                end
            end
            if (BONUS_ON && bonus && (m_mode == M_RUN || m_mode == M_PAUSE))
                t = (t + BONUS_SEC > TIM_MAX) ? TIM_MAX : t + BONUS_SEC;
            if (m_mode == M_IDLE && !pause)       m_mode = M_RUN;
            else if (m_mode == M_RUN && pause)    m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE && !pause) m_mode = M_RUN;
            if (ticked && t <= 0) begin
                t = 0;
                m_mode = M_DONE;
                m_exp = 1'b1;
            end
            m_tim = t;
        end
    endtask

    function automatic bit m_warn();
        return (m_mode == M_RUN || m_mode == M_PAUSE) && m_tim > 0 && m_tim <= WARN_SEC;
    endfunction

    task automatic check_all(input string tag);
        checks++;
        assert (tim === 4'(m_tim)) else begin
            errors++; $error("FAIL %s tim got %0d want %0d", tag, tim, m_tim);
        end
        checks++;
        assert (warn === m_warn()) else begin
            errors++; $error("FAIL %s warn got %b want %b", tag, warn, m_warn());
        end
        checks++;
        assert (expired === m_exp) else begin
            errors++; $error("FAIL %s expired got %b want %b", tag, expired, m_exp);
        end
        checks++;
        assert (running === (m_mode == M_RUN)) else begin
            errors++; $error("FAIL %s running got %b want %b", tag, running, (m_mode == M_RUN));
        end
    endtask

    task automatic check_val(input string tag, input logic [SEC_W-1:0] got, input int want);
        checks++;
        assert (got === 4'(want)) else begin
            errors++; $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (Reset) model_reset();
        else       model_edge();
        @(negedge clk);
        if (expired === 1'b1) exp_seen++;
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        Reset = 1'b1; gameStart = 1'b0; gameEnd = 1'b0; pause = 1'b0; bonus = 1'b0; level = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check_val("reset_tim", tim, 8);
        check_val("reset_running", 4'(running), 0);

        // Full countdown from 8 to 0 with one expired pulse, then DONE holds 0.
        Reset = 1'b0; gameStart = 1'b1;
        exp_seen = 0;
        steps(40, "countdown");
        check_val("expired_pulses", 4'(exp_seen), 1);
        check_val("done_tim", tim, 0);

        // Level changes mid-count.
        gameStart = 1'b0; step("to_idle");
        gameStart = 1'b1; steps(6, "restart");
        check_val("pre_level_tim", tim, 7);
        level = 4'd1; step("level1");
        check_val("level1_tim", tim, 5);
        steps(2, "level1_run");
        level = 4'd3; step("level3");
        check_val("level3_floor", tim, 2);
        level = 4'd2; step("level_down");
        check_val("level_down_tim", tim, 2);
        check_val("level_down_warn", 4'(warn), 1);

        // Reset between edges acts without a clock.
        #2 Reset = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        check_val("async_tim", tim, 8);
        check_val("async_warn", 4'(warn), 0);
        @(negedge clk);
        Reset = 1'b0; level = '0;

        // Pause at tim=6, then resume the held prescaler.
        steps(10, "to_six");
        check_val("pause_start_tim", tim, 6);
        pause = 1'b1; steps(10, "paused");
        check_val("paused_tim", tim, 6);
        check_val("paused_running", 4'(running), 0);
        pause = 1'b0; steps(3, "resume");
        check_val("resume_hold", tim, 6);
        step("resume_tick");
        check_val("resume_dec", tim, 5);

        // gameEnd at tim=4.
        for (int i = 0; i < 40 && m_tim != 4; i++) step("to_four");
        check_val("at_four", tim, 4);
        gameEnd = 1'b1; step("game_end");
        check_val("end_tim", tim, 8);
        check_val("end_running", 4'(running), 0);
        check_val("end_warn", 4'(warn), 0);
        gameEnd = 1'b0; steps(5, "end_restart");
        check_val("end_restart_tim", tim, 7);

`ifdef LEVEL_TIMER_BONUS_EN
        bonus = 1'b1; step("bonus12"); bonus = 1'b0;
        check_val("bonus_12", tim, 12);
        bonus = 1'b1; step("bonus_sat"); bonus = 1'b0;
        check_val("bonus_sat", tim, 15);
        for (int i = 0; i < 100 && !(m_tim == 3 && m_left == 1 && m_mode == M_RUN); i++) step("to_three");
        check_val("three_tim", tim, 3);
        check_val("three_warn", 4'(warn), 1);
        bonus = 1'b1; step("bonus_tick"); bonus = 1'b0;
        check_val("bonus_tick_tim", tim, 7);
        check_val("bonus_tick_warn", 4'(warn), 0);
        gameStart = 1'b0; step("bonus_idle_prep");
        bonus = 1'b1; step("bonus_idle"); bonus = 1'b0;
        check_val("bonus_idle_tim", tim, 8);
        gameStart = 1'b1;
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            gameStart = ($urandom_range(0, 39) != 0);
            gameEnd   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            if ($urandom_range(0, 24) == 0) level = LEVEL_W'($urandom_range(0, 15));
            bonus     = BONUS_ON && ($urandom_range(0, 19) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
